// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: a prescaler produces a slow tick, and each channel
// runs OFF / ON / BLINK / PULSE with its own period counted in ticks.
module led_pattern_gen #(
  parameter int CLK_HZ         = 27000000,
  parameter int TICK_HZ        = 1000,
  parameter int CHANNELS       = 6,
  parameter int PERIOD_BITS    = 12,
  parameter int LED_ACTIVE_LOW = 1,
  localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [CW-1:0]          cfg_ch,
  input  logic [1:0]             cfg_mode,
  input  logic [PERIOD_BITS-1:0] cfg_period,
  input  logic                   sync,
  output logic [CHANNELS-1:0]    led,
  output logic [CHANNELS-1:0]    active,
  output logic                   tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
  localparam logic LED_POL = (LED_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PULSE = 2'd3
  } mode_e;

  logic [PW-1:0]          pcnt_q, pcnt_d;
  logic                   tick_q, tick_d;
  mode_e                  mode_q   [CHANNELS];
  mode_e                  mode_d   [CHANNELS];
  logic [PERIOD_BITS-1:0] period_q [CHANNELS];
  logic [PERIOD_BITS-1:0] period_d [CHANNELS];
  logic [PERIOD_BITS-1:0] cnt_q    [CHANNELS];
  logic [PERIOD_BITS-1:0] cnt_d    [CHANNELS];
  logic [PERIOD_BITS-1:0] last_cnt [CHANNELS];
  logic [CHANNELS-1:0]    level_q, level_d;

  always_comb begin
    pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + 1'b1;
    tick_d = (pcnt_q == PCNT_LAST);
  end

  // A period of 0 behaves as 1, so the terminal count is clamped at 0.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      last_cnt[i] = (period_q[i] == '0) ? '0 : period_q[i] - 1'b1;
    end
  end

  // Per channel: a write wins over sync, and sync wins over tick.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < CHANNELS; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      cnt_d[i]    = cnt_q[i];
      if (cfg_we && (32'(cfg_ch) == 32'(i))) begin
        mode_d[i]   = mode_e'(cfg_mode);
        period_d[i] = cfg_period;
        cnt_d[i]    = '0;
        level_d[i]  = (cfg_mode != 2'd0);
      end else if (sync && (mode_q[i] == MODE_BLINK)) begin
        cnt_d[i]   = '0;
        level_d[i] = 1'b1;
      end else if (tick_q) begin
        case (mode_q[i])
          MODE_BLINK: begin
            if (cnt_q[i] == last_cnt[i]) begin
              cnt_d[i]   = '0;
              level_d[i] = ~level_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          MODE_PULSE: begin
            if (cnt_q[i] == last_cnt[i]) begin
              cnt_d[i]   = '0;
              level_d[i] = 1'b0;
              mode_d[i]  = MODE_OFF;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q  <= '0;
      tick_q  <= 1'b0;
      level_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      pcnt_q  <= pcnt_d;
      tick_q  <= tick_d;
      level_q <= level_d;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= mode_d[i];
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  always_comb begin
    led    = '0;
    active = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      led[i]    = level_q[i] ^ LED_POL;
      active[i] = (mode_q[i] != MODE_OFF);
    end
  end

  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed vector table, hand-written corner
// sequences, and random traffic checked against a tick-count reference model.
module tb_led_pattern_gen;

  localparam int CLK_HZ   = 100;
  localparam int TICK_HZ  = 10;
  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam int CHANNELS = 4;
  localparam int PB       = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [1:0]    cfg_mode;
  logic [PB-1:0] cfg_period;
  logic          sync;
  logic [3:0]    led;
  logic [3:0]    active;
  logic          tick;

  // Three-channel instance: the only way to present an out-of-range channel
  // number on a 2-bit channel port.
  logic          d3_we;
  logic [1:0]    d3_ch;
  logic [1:0]    d3_mode;
  logic [PB-1:0] d3_period;
  logic          d3_sync;
  logic [2:0]    d3_led;
  logic [2:0]    d3_active;
  logic          d3_tick;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CHANNELS(CHANNELS),
    .PERIOD_BITS(PB), .LED_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .sync(sync),
    .led(led), .active(active), .tick(tick)
  );

  led_pattern_gen #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CHANNELS(3),
    .PERIOD_BITS(PB), .LED_ACTIVE_LOW(1)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(d3_we), .cfg_ch(d3_ch),
    .cfg_mode(d3_mode), .cfg_period(d3_period), .sync(d3_sync),
    .led(d3_led), .active(d3_active), .tick(d3_tick)
  );

  // ---------------- reference model ----------------
  // Each channel remembers only its mode, P and how many ticks have elapsed
  // since it was (re)started; the lamp is derived arithmetically.
  int m_mode [CHANNELS];
  int m_p    [CHANNELS];
  int m_n    [CHANNELS];
  int cyc;
  int checks = 0;
  int errors = 0;

  function automatic void model_reset();
    for (int i = 0; i < CHANNELS; i++) begin
      m_mode[i] = 0;
      m_p[i]    = 1;
      m_n[i]    = 0;
    end
    cyc = 0;
  endfunction

  function automatic void model_edge();
    bit tick_m;
    tick_m = (cyc > 0) && (cyc % DIV == 0);
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_we && int'(cfg_ch) == i) begin
        m_mode[i] = int'(cfg_mode);
        m_p[i]    = (cfg_period == 0) ? 1 : int'(cfg_period);
        m_n[i]    = 0;
      end else if (sync && m_mode[i] == 2) begin
        m_n[i] = 0;
      end else if (tick_m && m_mode[i] >= 2) begin
        m_n[i]++;
        if (m_mode[i] == 3 && m_n[i] >= m_p[i]) begin
          m_mode[i] = 0;
          m_n[i]    = 0;
        end
      end
    end
  endfunction

  function automatic logic [3:0] model_led();
    logic [3:0] l;
    bit lit;
    l = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      lit = (m_mode[i] == 1) || (m_mode[i] == 3) ||
            (m_mode[i] == 2 && ((m_n[i] / m_p[i]) % 2 == 0));
      l[i] = ~lit;
    end
    return l;
  endfunction

  function automatic logic [3:0] model_active();
    logic [3:0] a;
    a = '0;
    for (int i = 0; i < CHANNELS; i++) a[i] = (m_mode[i] != 0);
    return a;
  endfunction

  function automatic logic model_tick();
    return (cyc > 0) && (cyc % DIV == 0);
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", name, got, exp, cyc, $time);
    end
  endtask

  // One clock edge: advance the model with the inputs the DUT sampled, then
  // compare all outputs 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      model_edge();
      cyc++;
    end
    #1;
    check("led_vs_model",    32'(led),    32'(model_led()));
    check("active_vs_model", 32'(active), 32'(model_active()));
    check("tick_vs_model",   32'(tick),   32'(model_tick()));
  endtask

  task automatic idle_inputs();
    cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_period = '0; sync = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       we;
    logic [1:0] ch;
    logic [1:0] mode;
    logic [3:0] period;
    logic       sy;
    int         wait_cyc;
    logic [3:0] exp_led;
    logic [3:0] exp_active;
    logic       exp_tick;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic we, input logic [1:0] ch, input logic [1:0] mode,
                     input logic [3:0] period, input logic sy, input int wait_cyc,
                     input logic [3:0] el, input logic [3:0] ea, input logic et);
    vec_t v;
    v.we = we; v.ch = ch; v.mode = mode; v.period = period; v.sy = sy;
    v.wait_cyc = wait_cyc; v.exp_led = el; v.exp_active = ea; v.exp_tick = et;
    vq.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst_n = 1'b0;
    idle_inputs();
    d3_we = 1'b0; d3_ch = '0; d3_mode = '0; d3_period = '0; d3_sync = 1'b0;
    model_reset();

    // Reset state.
    repeat (3) step();
    check("reset_led",    32'(led),    32'h0000_000f);
    check("reset_active", 32'(active), 32'h0);
    rst_n = 1'b1;

    // Timeline: cyc = edges since reset release; tick high while cyc%10==0.
    //  we ch mode per sy wait  led      active   tick
    add(0, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 0); // cyc 1
    add(1, 0, 2, 3, 0,  1, 4'b1110, 4'b0001, 0); // cyc 2   ch0 BLINK P=3
    add(0, 0, 0, 0, 0, 28, 4'b1110, 4'b0001, 1); // cyc 30
    add(0, 0, 0, 0, 0,  1, 4'b1111, 4'b0001, 0); // cyc 31  3rd tick: dark
    add(0, 0, 0, 0, 0, 29, 4'b1111, 4'b0001, 1); // cyc 60
    add(0, 0, 0, 0, 0,  1, 4'b1110, 4'b0001, 0); // cyc 61  lit again
    add(1, 1, 3, 2, 0,  1, 4'b1100, 4'b0011, 0); // cyc 62  ch1 PULSE P=2
    add(0, 0, 0, 0, 0, 18, 4'b1100, 4'b0011, 1); // cyc 80
    add(0, 0, 0, 0, 0,  1, 4'b1110, 4'b0001, 0); // cyc 81  pulse ends
    add(1, 1, 3, 0, 0,  1, 4'b1100, 4'b0011, 0); // cyc 82  PULSE period 0
    add(0, 0, 0, 0, 0,  8, 4'b1100, 4'b0011, 1); // cyc 90
    add(0, 0, 0, 0, 0,  1, 4'b1111, 4'b0001, 0); // cyc 91  ends on 1st tick
    add(1, 3, 1, 0, 0,  1, 4'b0111, 4'b1001, 0); // cyc 92  ch3 ON
    add(1, 2, 2, 2, 0,  3, 4'b0011, 4'b1101, 0); // cyc 95  ch2 BLINK P=2
    add(0, 0, 0, 0, 0, 35, 4'b0110, 4'b1101, 1); // cyc 130 tick cycle
    add(1, 2, 3, 1, 1,  1, 4'b0010, 4'b1101, 0); // cyc 131 sync + write ch2
    add(0, 0, 0, 0, 0, 10, 4'b0110, 4'b1001, 0); // cyc 141 ch2 pulse over
    add(0, 0, 0, 0, 0, 19, 4'b0110, 4'b1001, 1); // cyc 160 ch0 still lit
    add(0, 0, 0, 0, 0,  1, 4'b0111, 4'b1001, 0); // cyc 161 ch0 toggles
    add(1, 1, 3, 5, 0,  1, 4'b0101, 4'b1011, 0); // cyc 162 ch1 PULSE P=5

    for (int k = 0; k < vq.size(); k++) begin
      v = vq[k];
      cfg_we = v.we; cfg_ch = v.ch; cfg_mode = v.mode; cfg_period = v.period; sync = v.sy;
      step();
      idle_inputs();
      for (int w = 1; w < v.wait_cyc; w++) step();
      check($sformatf("vec%0d_led", k),    32'(led),    32'(v.exp_led));
      check($sformatf("vec%0d_active", k), 32'(active), 32'(v.exp_active));
      check($sformatf("vec%0d_tick", k),   32'(tick),   32'(v.exp_tick));
    end

    // Mid-run reset while ch1 PULSE is running: outputs clear at once.
    rst_n = 1'b0;
    #1;
    check("midreset_led",    32'(led),    32'h0000_000f);
    check("midreset_active", 32'(active), 32'h0);
    check("midreset_tick",   32'(tick),   32'h0);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (9) step();
    check("restart_tick_c9",  32'(tick), 32'h0);
    step();
    check("restart_tick_c10", 32'(tick), 32'h1);
    step();
    check("restart_tick_c11", 32'(tick), 32'h0);
    check("restart_d3_tick",  32'(d3_tick), 32'h0);

    // Out-of-range channel on the three-channel instance.
    d3_we = 1'b1; d3_ch = 2'd0; d3_mode = 2'd1; d3_period = 4'd0;
    step();
    d3_we = 1'b0;
    check("d3_on_led",    32'(d3_led),    32'h6);
    check("d3_on_active", 32'(d3_active), 32'h1);
    d3_we = 1'b1; d3_ch = 2'd3; d3_mode = 2'd0;
    step();
    d3_mode = 2'd2;
    step();
    d3_we = 1'b0;
    step();
    check("d3_invalid_led",    32'(d3_led),    32'h6);
    check("d3_invalid_active", 32'(d3_active), 32'h1);

    // Random traffic, including colliding writes, syncs and ticks.
    for (int r = 0; r < 3000; r++) begin
      cfg_we     = ($urandom_range(0, 7) == 0);
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_mode   = 2'($urandom_range(0, 3));
      cfg_period = ($urandom_range(0, 5) == 0) ? 4'hf : 4'($urandom_range(0, 4));
      sync       = ($urandom_range(0, 40) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
